// File: rtl/operand_sequencer.sv
// Two-beat operand collector feeding an external combinational adder; the
// registered sum, its carry-out and a hand-off count go out over a valid/ready port.
module operand_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  input  logic [N-1:0] sum_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_carry,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {StIdle, StGotA, StCapt, StOut} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] op_a_q, op_a_d;
  logic [N-1:0] op_b_q, op_b_d;
  logic [N-1:0] res_data_q, res_data_d;
  logic         res_carry_q, res_carry_d;
  logic [15:0]  op_count_q, op_count_d;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    op_count_d  = op_count_q;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_a_d  = in_data;
          state_d = StGotA;
        end
      end
      StGotA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_b_d  = in_data;
          state_d = StCapt;
        end
      end
      StCapt: begin
        // Operands have been stable for a full cycle, so the adder has settled.
        // An unsigned sum that wrapped is smaller than either operand.
        res_data_d  = sum_in;
        res_carry_d = (sum_in < op_a_q);
        state_d     = StOut;
      end
      StOut: begin
        res_valid = 1'b1;
        if (res_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      op_count_q  <= op_count_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign op_count  = op_count_q;

endmodule
